// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiters: state encoding and the
// default idle-owner timeout used when UART_ARB_TIMEOUT_EN is defined.
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 1_000_000;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: one-hot pick of the first set request
// found searching upward from (ptr+1) mod N, wrapping around.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    idx   = '0;
    // The last candidate examined (k == N) is ptr itself.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        pick[idx] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmit channel
// between N byte-stream requesters. Optional owner-idle timeout: UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N       = 3,
  parameter int unsigned WIDTH   = 8
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
`endif
) (
  input  logic               clk_100M,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] req_data,
  input  logic [N-1:0]       req_rdy,
  input  logic [N-1:0]       req_last,
  output logic [N-1:0]       req_ack,
  output logic [WIDTH-1:0]   tx_data,
  output logic               tx_rdy,
  input  logic               tx_ack,
  output logic [N-1:0]       grant,
`ifdef UART_ARB_TIMEOUT_EN
  output logic               timeout_o,
`endif
  output logic               busy
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  arb_state_e        state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [N-1:0]      pick;
  logic              pick_valid;
  logic [PW-1:0]     g;
  logic [WIDTH-1:0]  data_mux;
  logic              own_rdy, own_last, xfer;
`ifdef UART_ARB_TIMEOUT_EN
  logic [31:0]       cnt_q, cnt_d;
  logic              timeout_q, timeout_d;
`endif

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (req_rdy),
    .ptr   (ptr_q),
    .pick  (pick),
    .valid (pick_valid)
  );

  // grant_q is zero outside GRANT, so the passthrough yields 0 in IDLE.
  always_comb begin
    g        = '0;
    data_mux = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        g        = PW'(i);
        data_mux = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign own_rdy  = |(req_rdy & grant_q);
  assign own_last = |(req_last & grant_q);
  assign xfer     = own_rdy & tx_ack;

  assign tx_rdy   = own_rdy;
  assign tx_data  = data_mux;
  assign req_ack  = grant_q & {N{xfer}};
  assign grant    = grant_q;
  assign busy     = (state_q == ST_GRANT);
`ifdef UART_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d     = '0;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (xfer && own_last) begin
          grant_d = '0;
          ptr_d   = g;
          state_d = ST_IDLE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        // Counts consecutive owner-idle cycles; release on the TIMEOUT-th one.
        else if (!own_rdy) begin
          cnt_d = cnt_q + 32'd1;
          if (cnt_d == TIMEOUT) begin
            cnt_d     = '0;
            timeout_d = 1'b1;
            grant_d   = '0;
            ptr_d     = g;
            state_d   = ST_IDLE;
          end
        end
`endif
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter: requester queues feed the
// DUT, a simple uart model acks one cycle after tx_rdy, transfers are logged.
module tb_uart_tx_arbiter;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;

  logic             clk_100M = 1'b0;
  logic             rst;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_rdy, req_last, req_ack, grant;
  logic [W-1:0]     tx_data;
  logic             tx_rdy, tx_ack, busy;
`ifdef UART_ARB_TIMEOUT_EN
  logic             timeout_o;
`endif

  always #5 clk_100M = ~clk_100M;

  uart_tx_arbiter #(
    .N       (N),
    .WIDTH   (W)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT (100)
`endif
  ) dut (
    .clk_100M  (clk_100M),
    .rst       (rst),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .tx_data   (tx_data),
    .tx_rdy    (tx_rdy),
    .tx_ack    (tx_ack),
    .grant     (grant),
`ifdef UART_ARB_TIMEOUT_EN
    .timeout_o (timeout_o),
`endif
    .busy      (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester model state: per-requester packet bytes {last, data}
  logic [8:0]  pk [N][16];
  int unsigned head [N];
  int unsigned cnt  [N];
  int unsigned stall_len [N];
  int unsigned stall_cnt [N];
  int unsigned ack_pulses [N];
  bit          ack_force;
  bit          stall_active;
  int unsigned stall_seen, stall_bad;
  logic [W-1:0] log_data [$];
  logic [N-1:0] log_grant [$];
  int unsigned  gaps [$];
  int unsigned  idle_run;
  int unsigned  cyc;
  logic         prev_rdy, prev_xfer;
  logic [N-1:0] prev_ack;

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      head[i] = 0; cnt[i] = 0; stall_len[i] = 0; stall_cnt[i] = 0; ack_pulses[i] = 0;
    end
    log_data.delete(); log_grant.delete(); gaps.delete();
    idle_run = 0; stall_seen = 0; stall_bad = 0; ack_force = 1'b0;
    prev_rdy = 1'b0; prev_xfer = 1'b0; prev_ack = '0;
  endtask

  task automatic add(input int i, input logic [7:0] d, input logic l);
    pk[i][cnt[i]] = {l, d};
    cnt[i]++;
  endtask

  task automatic drive();
    stall_active = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (prev_ack[i]) begin
        head[i]++;
        if (head[i] == 1 && stall_len[i] > 0) stall_cnt[i] = stall_len[i];
      end
    end
    for (int i = 0; i < N; i++) begin
      req_data[i*W +: W] = '0;
      req_last[i] = 1'b0;
      req_rdy[i]  = 1'b0;
      if (stall_cnt[i] > 0) begin
        stall_cnt[i]--;
        stall_active = 1'b1;
      end else if (head[i] < cnt[i]) begin
        req_rdy[i]         = 1'b1;
        req_data[i*W +: W] = pk[i][head[i]][7:0];
        req_last[i]        = pk[i][head[i]][8];
      end
    end
    tx_ack = ack_force | (prev_rdy & ~prev_xfer);
  endtask

  task automatic sample();
    logic xfer;
    xfer = tx_rdy & tx_ack;
    if (xfer) begin
      log_data.push_back(tx_data);
      log_grant.push_back(grant);
    end
    for (int i = 0; i < N; i++) if (req_ack[i]) ack_pulses[i]++;
    if (busy) begin
      if (idle_run > 0) gaps.push_back(idle_run);
      idle_run = 0;
    end else if (|req_rdy) begin
      idle_run++;
    end
    if (stall_active) begin
      stall_seen++;
      if (tx_rdy !== 1'b0 || grant !== 3'b010) stall_bad++;
    end
    prev_rdy  = tx_rdy;
    prev_xfer = xfer;
    prev_ack  = req_ack;
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1 drive();
    #1 sample();
    cyc++;
  endtask

  function automatic bit all_done();
    bit d;
    d = !busy;
    for (int i = 0; i < N; i++) if (head[i] < cnt[i]) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_done(input string tag, input int unsigned max_cyc);
    int unsigned k;
    k = 0;
    while (!all_done() && k < max_cyc) begin
      tick();
      k++;
    end
    check_eq({tag, "_done"}, 32'(all_done()), 32'd1);
  endtask

  task automatic check_gaps(input string tag, input int unsigned n);
    check_eq({tag, "_ngaps"}, gaps.size(), n);
    for (int i = 0; i < gaps.size(); i++) check_eq({tag, "_gap"}, gaps[i], 32'd1);
  endtask

  logic [7:0]   exp_c_data  [6] = '{8'h11, 8'h12, 8'h21, 8'h22, 8'h01, 8'h02};
  logic [N-1:0] exp_c_grant [6] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};

  initial begin
    int unsigned k;
    cyc = 0;
    req_data = '0; req_rdy = '0; req_last = '0; tx_ack = 1'b0;
    clear_model();

    // Reset with a request pending: nothing may be granted or passed through
    rst = 1'b1;
    add(2, 8'hEE, 1'b1);
    ack_force = 1'b1;
    repeat (3) tick();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_tx_rdy", 32'(tx_rdy), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    check_eq("rst_req_ack", 32'(req_ack), 32'd0);
    clear_model();
    tick();
    rst = 1'b0;
    tick();

    // Single requester, latency and two-byte packet
    add(0, 8'h41, 1'b0);
    add(0, 8'h42, 1'b1);
    tick();
    check_eq("lat_tx_rdy", 32'(tx_rdy), 32'd0);
    check_eq("lat_grant", 32'(grant), 32'd0);
    tick();
    check_eq("single_grant", 32'(grant), 32'b001);
    check_eq("single_tx_rdy", 32'(tx_rdy), 32'd1);
    run_until_done("single", 50);
    check_eq("single_nbytes", log_data.size(), 32'd2);
    if (log_data.size() == 2) begin
      check_eq("single_b0", 32'(log_data[0]), 32'h41);
      check_eq("single_b1", 32'(log_data[1]), 32'h42);
    end
    check_eq("single_acks", ack_pulses[0], 32'd2);
    check_eq("single_grant_end", 32'(grant), 32'd0);
    check_eq("single_busy_end", 32'(busy), 32'd0);

    // Same requester re-granted for consecutive packets, one idle cycle between
    clear_model();
    add(0, 8'h51, 1'b1);
    add(0, 8'h52, 1'b1);
    run_until_done("regrant", 50);
    check_eq("regrant_nbytes", log_data.size(), 32'd2);
    if (log_data.size() == 2) begin
      check_eq("regrant_b1", 32'(log_data[1]), 32'h52);
      check_eq("regrant_g1", 32'(log_grant[1]), 32'b001);
    end
    check_gaps("regrant", 2);

    // Contention from reset: order 1,2,0, packets contiguous
    rst = 1'b1;
    clear_model();
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      add(i, 8'(i * 16 + 1), 1'b0);
      add(i, 8'(i * 16 + 2), 1'b1);
    end
    run_until_done("cont", 200);
    check_eq("cont_nbytes", log_data.size(), 32'd6);
    if (log_data.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check_eq("cont_data", 32'(log_data[i]), 32'(exp_c_data[i]));
        check_eq("cont_grant", 32'(log_grant[i]), 32'(exp_c_grant[i]));
      end
    end
    check_gaps("cont", 3);

    // Owner stalls mid-packet while another requester waits
    clear_model();
    add(1, 8'hA1, 1'b0);
    add(1, 8'hA2, 1'b1);
    add(2, 8'hB1, 1'b1);
    stall_len[1] = 50;
    run_until_done("stall", 300);
    check_eq("stall_cycles", stall_seen, 32'd50);
    check_eq("stall_bad", stall_bad, 32'd0);
    check_eq("stall_nbytes", log_data.size(), 32'd3);
    if (log_data.size() == 3) begin
      check_eq("stall_b1", 32'(log_data[1]), 32'hA2);
      check_eq("stall_b2", 32'(log_data[2]), 32'hB1);
      check_eq("stall_g2", 32'(log_grant[2]), 32'b100);
    end

    // Reset while req2's second byte is offered
    clear_model();
    add(2, 8'hC1, 1'b0);
    add(2, 8'hC2, 1'b1);
    k = 0;
    while (log_data.size() < 1 && k < 50) begin
      tick();
      k++;
    end
    check_eq("rstmid_first", log_data.size(), 32'd1);
    tick();
    check_eq("rstmid_c2_offered", 32'(tx_data), 32'hC2);
    rst = 1'b1;
    tick();
    check_eq("rstmid_grant", 32'(grant), 32'd0);
    check_eq("rstmid_tx_rdy", 32'(tx_rdy), 32'd0);
    check_eq("rstmid_req_ack", 32'(req_ack), 32'd0);
    check_eq("rstmid_nbytes", log_data.size(), 32'd1);
    clear_model();
    tick();
    rst = 1'b0;
    add(0, 8'hD1, 1'b1);
    run_until_done("postrst", 50);
    check_eq("postrst_nbytes", log_data.size(), 32'd1);
    if (log_data.size() == 1) check_eq("postrst_grant", 32'(log_grant[0]), 32'b001);

    // Spurious uart ack while idle
    clear_model();
    ack_force = 1'b1;
    repeat (10) tick();
    check_eq("spur_acks", ack_pulses[0] + ack_pulses[1] + ack_pulses[2], 32'd0);
    check_eq("spur_busy", 32'(busy), 32'd0);
    ack_force = 1'b0;
    tick();

`ifdef UART_ARB_TIMEOUT_EN
    // Owner goes silent after one byte; released after 100 idle cycles
    begin
      int unsigned x_cyc, t_cyc;
      bit seen;
      clear_model();
      add(0, 8'h61, 1'b0);
      k = 0;
      while (log_data.size() < 1 && k < 20) begin
        tick();
        k++;
      end
      check_eq("to_first", log_data.size(), 32'd1);
      x_cyc = cyc;
      add(1, 8'h71, 1'b1);
      seen = 1'b0;
      t_cyc = 0;
      k = 0;
      while (!seen && k < 300) begin
        tick();
        k++;
        if (timeout_o === 1'b1) begin
          seen  = 1'b1;
          t_cyc = cyc;
        end
      end
      check_eq("to_seen", 32'(seen), 32'd1);
      // registered pulse appears the cycle after the 100th idle cycle
      check_eq("to_delay", t_cyc - x_cyc, 32'd101);
      tick();
      check_eq("to_pulse_width", 32'(timeout_o), 32'd0);
      run_until_done("to", 50);
      check_eq("to_nbytes", log_data.size(), 32'd2);
      if (log_data.size() == 2) begin
        check_eq("to_b1", 32'(log_data[1]), 32'h71);
        check_eq("to_g1", 32'(log_grant[1]), 32'b010);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
